alu4: RTL and testbench
=======================

Name: alu4

Overview:
- 4-bit registered arithmetic/logic unit with a 3-bit opcode.
- Computes one of eight operations on OP1/OP2 and registers the result and status flags on the rising clock edge.
- Leaf datapath block; consumed by control/sequencing logic and by formal property harnesses.

Parameters:
- WIDTH, 4, operand/result width (design and test plan fixed at 4; other values not required to be verified).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- OPCODE  in  3  operation select.
- OP1  in  WIDTH  first operand (shift/NOT source).
- OP2  in  WIDTH  second operand.
- RESULT  out  WIDTH  registered result.
- CARRY  out  1  registered carry/borrow/shift-out flag.
- ZERO  out  1  registered flag: RESULT == 0.
- NEG  out  1  registered flag: RESULT[WIDTH-1].
- OVF  out  1  registered signed-overflow flag.

Behaviour:
- Reset: on a rising clk edge with rstn=0, RESULT=0, CARRY=0, ZERO=0, NEG=0, OVF=0. Reset has priority over any opcode.
- ZERO is forced to 0 during reset, not 1.
- Reset asserted mid-stream discards the in-flight computation; no state other than the output registers.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N. Outputs hold between edges. No handshake; a new operation is accepted every cycle.
- Opcodes (unsigned 4-bit, results truncated to WIDTH):
  - 000 ADD: {CARRY,RESULT} = OP1+OP2. OVF = signed overflow (operand signs equal, result sign differs).
  - 001 SUB: RESULT = OP1-OP2 mod 16. CARRY = borrow (1 iff OP1<OP2 unsigned). OVF = operand signs differ and result sign differs from OP1.
  - 010 AND: RESULT = OP1&OP2.
  - 011 OR: RESULT = OP1|OP2.
  - 100 XOR: RESULT = OP1^OP2.
  - 101 NOT: RESULT = ~OP1 (OP2 ignored).
  - 110 SHL: RESULT = OP1<<1, LSB filled with 0. CARRY = OP1[3].
  - 111 SHR: RESULT = OP1>>1 logical, MSB filled with 0. CARRY = OP1[0].
- CARRY=0 for opcodes 010-101. OVF=0 for all opcodes except ADD/SUB.
- ZERO and NEG are derived from the next RESULT value and registered in the same edge as RESULT.
- Outputs never X after the first reset edge. Behaviour before the first reset is unspecified; formal starts from arbitrary register contents.

Decomposition:
- Package alu_pkg: opcode constants/enum (OP_ADD..OP_SHR), WIDTH default.
- One natural sub-module: alu_datapath, purely combinational. It takes OPCODE/OP1/OP2 and produces next RESULT/CARRY/OVF.
- Top-level alu4 contains the output registers, the sync reset and ZERO/NEG derivation.

Test Plan:
- Reset: rstn=0, OPCODE=111, OP1=1111, OP2=0000 for 2 edges -> RESULT=0000, CARRY=0, ZERO=0, NEG=0, OVF=0.
- ADD wrap: rstn=1, OPCODE=000, OP1=0111, OP2=0001 -> next cycle RESULT=1000, CARRY=0, OVF=1, NEG=1. Then OP1=1111, OP2=0001 -> RESULT=0000, CARRY=1, ZERO=1, OVF=0.
- SUB borrow: OPCODE=001, OP1=0010, OP2=0011 -> RESULT=1111, CARRY=1, NEG=1, OVF=0. Then OP1=1000, OP2=0001 -> RESULT=0111, OVF=1, CARRY=0.
- Logic: OPCODE=010/011/100/101 with OP1=1100, OP2=1010 -> RESULT 1000/1110/0110/0011 on successive cycles, CARRY=0, OVF=0.
- Shifts: OPCODE=110, OP1=1001 -> RESULT=0010, CARRY=1. Then OPCODE=111, OP1=1111 -> RESULT=0111, CARRY=1, NEG=0.
- Mid-stream reset: ADD running back-to-back, drop rstn for one edge -> outputs all 0 after that edge. Next edge with rstn=1 resumes with the correct 1-cycle-latency result.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encoding and default width for the alu4 block.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alu_datapath
// Description : Combinational ALU core. Produces the next result, carry/borrow
//               /shift-out flag and signed-overflow flag for one operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  // One extra bit on add/sub captures carry-out and borrow respectively.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, op1} + {1'b0, op2};
  assign diff_ext = {1'b0, op1} - {1'b0, op2};

  // Operation select; flags default to 0 so only ADD/SUB/shifts raise them.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: begin
        result = sum_ext[WIDTH-1:0];
        carry  = sum_ext[WIDTH];
        ovf    = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                 (sum_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff_ext[WIDTH-1:0];
        // Wrap-around of the extended subtraction sets the top bit exactly
        // when op1 < op2 unsigned, i.e. a borrow.
        carry  = diff_ext[WIDTH];
        ovf    = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                 (diff_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_XOR: result = op1 ^ op2;
      OP_NOT: result = ~op1;
      OP_SHL: begin
        result = {op1[WIDTH-2:0], 1'b0};
        carry  = op1[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, op1[WIDTH-1:1]};
        carry  = op1[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule : alu_datapath
`default_nettype wire

// File: rtl/alu4.sv
`default_nettype none
// ============================================================================
// Module      : alu4
// Description : Registered 4-bit ALU. One-cycle latency, new operation every
//               cycle, synchronous active-low reset clears all outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);

  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_ovf;

  alu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .opcode (OPCODE),
    .op1    (OP1),
    .op2    (OP2),
    .result (next_result),
    .carry  (next_carry),
    .ovf    (next_ovf)
  );

  // Output registers; ZERO/NEG come from the next result so they line up with
  // RESULT, and reset forces every flag (including ZERO) low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      RESULT <= '0;
      CARRY  <= 1'b0;
      ZERO   <= 1'b0;
      NEG    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      RESULT <= next_result;
      CARRY  <= next_carry;
      ZERO   <= (next_result == '0);
      NEG    <= next_result[WIDTH-1];
      OVF    <= next_ovf;
    end
  end

endmodule : alu4
`default_nettype wire

// File: tb/tb_alu4.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4
// Description : Self-checking bench for alu4: directed cases plus randomized
//               operations against an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu4;

  logic       clk;
  logic       rstn;
  logic [2:0] OPCODE;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic [3:0] RESULT;
  logic       CARRY;
  logic       ZERO;
  logic       NEG;
  logic       OVF;

  int n_cmp;
  int n_mis;

  alu4 dut (
    .clk    (clk),
    .rstn   (rstn),
    .OPCODE (OPCODE),
    .OP1    (OP1),
    .OP2    (OP2),
    .RESULT (RESULT),
    .CARRY  (CARRY),
    .ZERO   (ZERO),
    .NEG    (NEG),
    .OVF    (OVF)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: returns {result[3:0], carry, zero, neg, ovf} from integer math.
  function automatic logic [7:0] ref_model(input bit rn, input int op, input int a, input int b);
    int r, c, o, sa, sb, sv;
    logic [3:0] rv;
    logic [7:0] pk;
    r = 0; c = 0; o = 0;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (!rn) return 8'h00;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b > 15); sv = sa + sb; o = (sv > 7 || sv < -8); end
      1: begin r = (a - b + 16) % 16; c = (a < b); sv = sa - sb; o = (sv > 7 || sv < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = (a * 2) % 16; c = (a >= 8); end
      default: begin r = a / 2; c = a % 2; end
    endcase
    rv = r[3:0];
    pk = {rv, c[0], (r == 0), (r >= 8), o[0]};
    return pk;
  endfunction

  // Apply one operation, let it register, then compare every output field.
  task automatic apply(input bit rn, input int op, input int a, input int b, input string tag);
    logic [7:0] e;
    rstn   = rn;
    OPCODE = op[2:0];
    OP1    = a[3:0];
    OP2    = b[3:0];
    e = ref_model(rn, op, a, b);
    @(posedge clk);
    #1;
    chk({tag, ".result"}, {4'h0, RESULT}, {4'h0, e[7:4]});
    chk({tag, ".carry"},  {7'h0, CARRY},  {7'h0, e[3]});
    chk({tag, ".zero"},   {7'h0, ZERO},   {7'h0, e[2]});
    chk({tag, ".neg"},    {7'h0, NEG},    {7'h0, e[1]});
    chk({tag, ".ovf"},    {7'h0, OVF},    {7'h0, e[0]});
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rstn = 1'b0; OPCODE = 3'b111; OP1 = 4'hF; OP2 = 4'h0;
    #2;

    // Reset: two edges with an active opcode on the inputs.
    apply(0, 7, 15, 0, "reset0");
    apply(0, 7, 15, 0, "reset1");

    // ADD wrap cases.
    apply(1, 0, 4'b0111, 4'b0001, "add_ovf");
    apply(1, 0, 4'b1111, 4'b0001, "add_carry");

    // SUB borrow and overflow.
    apply(1, 1, 4'b0010, 4'b0011, "sub_borrow");
    apply(1, 1, 4'b1000, 4'b0001, "sub_ovf");

    // Logic ops back-to-back.
    apply(1, 2, 4'b1100, 4'b1010, "and");
    apply(1, 3, 4'b1100, 4'b1010, "or");
    apply(1, 4, 4'b1100, 4'b1010, "xor");
    apply(1, 5, 4'b1100, 4'b1010, "not");

    // Shifts.
    apply(1, 6, 4'b1001, 4'b0000, "shl");
    apply(1, 7, 4'b1111, 4'b0000, "shr");

    // Mid-stream reset during back-to-back ADDs.
    apply(1, 0, 3, 4, "mid_add0");
    apply(1, 0, 5, 6, "mid_add1");
    apply(0, 0, 7, 7, "mid_rst");
    apply(1, 0, 9, 9, "mid_resume");
    apply(1, 0, 2, 1, "mid_add2");

    // Randomized operations with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
    end

    // Exhaustive ADD/SUB sweep for the overflow/borrow boundaries.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply(1, 0, a, b, "sweep_add");
        apply(1, 1, a, b, "sweep_sub");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_alu4
`default_nettype wire
